regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (WriteEn/WriteAddr/In) between two write-back
//  sources: A = ALU, B = memory load. Round-robin arbiter, valid/ready handshake per source.
//  Registered output stage. Drives the register file write port directly. Also counts
//  contention cycles for performance monitoring.
// PARAMETERS
//  DW         32  write data width; must match the register file
//  AW         5   write address width (32 registers)
//  ZERO_RO    1   1: a write to address 0 is accepted (handshake completes) but WriteEn stays 0
//  CNT_W      16  width of the ConflictCnt counter
// PORTS
//  Clk         in   1     clock, rising edge
//  Rst         in   1     synchronous reset, active-high
//  ValidA      in   1     source A has a write pending
//  AddrA       in   AW    source A destination register
//  DataA       in   DW    source A write data
//  ReadyA      out  1     source A write accepted this cycle (combinational)
//  ValidB      in   1     source B has a write pending
//  AddrB       in   AW    source B destination register
//  DataB       in   DW    source B write data
//  ReadyB      out  1     source B write accepted this cycle (combinational)
//  WriteEn     out  1     register file write enable (registered)
//  WriteAddr   out  AW    register file write address (registered)
//  In          out  DW    register file write data (registered)
//  ConflictCnt out  CNT_W saturating count of cycles with ValidA & ValidB
// BEHAVIOUR
//  - State: LastGnt (0 = A, 1 = B), output stage regs, ConflictCnt. Rst: LastGnt=1 (A wins first tie),
//    WriteEn=0, WriteAddr=0, In=0, ConflictCnt=0. ReadyA = ReadyB = 0 while Rst=1.
//  - Grant, combinational in cycle N: exactly one valid source -> that source.
//    Both valid -> the source != LastGnt. None valid -> no grant.
//    ReadyX = grant to X. ReadyA & ReadyB is never 1. The arbiter never stalls a lone requester.
//  - Transfer = ValidX & ReadyX. At edge end of N: LastGnt <= X; WriteAddr <= AddrX; In <= DataX;
//    WriteEn <= ~(ZERO_RO & AddrX==0). No transfer: WriteEn <= 0; WriteAddr and In hold.
//  - Latency: source handshake in cycle N -> WriteEn=1 in cycle N+1 -> register file updated at
//    edge end of N+1. Throughput: 1 write/cycle. Alternates A,B,A,B under continuous contention.
//  - Loser: holds Valid/Addr/Data stable until its Ready; it is granted the next cycle
//    (round-robin, max wait = 1 cycle).
//  - Same address from A and B in one cycle: no merging; two writes in grant order.
//    The final value is the second-granted source's data.
//  - ConflictCnt += 1 each non-reset cycle with ValidA & ValidB; saturates at all-ones, no wrap.
//  - Rst mid-operation: a registered write not yet visible is dropped (WriteEn=0 next cycle).
//    A source whose Ready was 0 during Rst must re-present after reset.
//  - No X propagation: AddrX/DataX ignored when ValidX=0.
// TESTING
//  1. Rst=1 3 cycles, all Valid=1 -> ReadyA=ReadyB=0, WriteEn=0, ConflictCnt=0 throughout.
//  2. Only ValidA, AddrA=5, DataA=0xDEADBEEF in cycle N -> ReadyA=1 in N;
//     WriteEn=1, WriteAddr=5, In=0xDEADBEEF in N+1; WriteEn=0 in N+2.
//  3. A and B valid continuously 6 cycles after reset -> grants A,B,A,B,A,B; ConflictCnt=6;
//     WriteAddr sequence matches grant order with 1-cycle lag.
//  4. A(addr 7, 0x1) and B(addr 7, 0x2) same cycle, LastGnt=1 -> A then B written;
//     a read of reg 7 after both writes returns 0x2.
//  5. ZERO_RO=1, ValidB, AddrB=0 -> ReadyB=1, WriteEn stays 0 next cycle.
//     Same test with ZERO_RO=0 -> WriteEn=1, WriteAddr=0.
//  6. CNT_W=4, 20 contention cycles -> ConflictCnt stops at 15. Rst asserted the cycle after a
//     grant -> WriteEn=0 the following cycle, ConflictCnt=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between an ALU (A) and a load unit (B).
// The winning write is registered one cycle before it reaches the register file.
module regfile_wb_arbiter #(
   parameter int DW      = 32,
   parameter int AW      = 5,
   parameter int ZERO_RO = 1,
   parameter int CNT_W   = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             ValidA,
   input  logic [AW-1:0]    AddrA,
   input  logic [DW-1:0]    DataA,
   output logic             ReadyA,
   input  logic             ValidB,
   input  logic [AW-1:0]    AddrB,
   input  logic [DW-1:0]    DataB,
   output logic             ReadyB,
   output logic             WriteEn,
   output logic [AW-1:0]    WriteAddr,
   output logic [DW-1:0]    In,
   output logic [CNT_W-1:0] ConflictCnt
);

   // Handshake: a source holds Valid/Addr/Data stable until it sees Ready in the same
   // cycle; Valid & Ready on a rising edge is one accepted write. Ready is 0 during Rst.

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             last_gnt_q, last_gnt_d;   // 0 = A won last, 1 = B won last
   logic             write_en_q, write_en_d;
   logic [AW-1:0]    write_addr_q, write_addr_d;
   logic [DW-1:0]    in_q, in_d;
   logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
   logic             grant_a, grant_b;

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!Rst) begin
         // On a tie the source that did not win last time is served.
         if (ValidA && ValidB) begin
            if (last_gnt_q) grant_a = 1'b1;
            else            grant_b = 1'b1;
         end else if (ValidA) begin
            grant_a = 1'b1;
         end else if (ValidB) begin
            grant_b = 1'b1;
         end
      end
   end

   always_comb begin
      last_gnt_d     = last_gnt_q;
      write_en_d     = 1'b0;
      write_addr_d   = write_addr_q;
      in_d           = in_q;
      conflict_cnt_d = conflict_cnt_q;
      if (grant_a) begin
         last_gnt_d   = 1'b0;
         write_addr_d = AddrA;
         in_d         = DataA;
         write_en_d   = !((ZERO_RO != 0) && (AddrA == '0));
      end else if (grant_b) begin
         last_gnt_d   = 1'b1;
         write_addr_d = AddrB;
         in_d         = DataB;
         write_en_d   = !((ZERO_RO != 0) && (AddrB == '0));
      end
      if (ValidA && ValidB && (conflict_cnt_q != CNT_MAX))
         conflict_cnt_d = conflict_cnt_q + CNT_ONE;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         last_gnt_q     <= 1'b1;
         write_en_q     <= 1'b0;
         write_addr_q   <= '0;
         in_q           <= '0;
         conflict_cnt_q <= '0;
      end else begin
         last_gnt_q     <= last_gnt_d;
         write_en_q     <= write_en_d;
         write_addr_q   <= write_addr_d;
         in_q           <= in_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign ReadyA      = grant_a;
   assign ReadyB      = grant_b;
   assign WriteEn     = write_en_q;
   assign WriteAddr   = write_addr_q;
   assign In          = in_q;
   assign ConflictCnt = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: three instances (default, ZERO_RO=0, CNT_W=4) share one stimulus
// stream; a behavioural model is checked every cycle and directed literals pin the key scenarios.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        va, vb;
   logic [4:0]  aa, ab;
   logic [31:0] da, db;

   logic        ready_a [3];
   logic        ready_b [3];
   logic        we      [3];
   logic [4:0]  wa      [3];
   logic [31:0] wd      [3];
   logic [15:0] cnt     [3];
   logic [3:0]  cnt2_raw;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter u0 (
      .Clk(clk), .Rst(rst),
      .ValidA(va), .AddrA(aa), .DataA(da), .ReadyA(ready_a[0]),
      .ValidB(vb), .AddrB(ab), .DataB(db), .ReadyB(ready_b[0]),
      .WriteEn(we[0]), .WriteAddr(wa[0]), .In(wd[0]), .ConflictCnt(cnt[0])
   );

   regfile_wb_arbiter #(.ZERO_RO(0)) u1 (
      .Clk(clk), .Rst(rst),
      .ValidA(va), .AddrA(aa), .DataA(da), .ReadyA(ready_a[1]),
      .ValidB(vb), .AddrB(ab), .DataB(db), .ReadyB(ready_b[1]),
      .WriteEn(we[1]), .WriteAddr(wa[1]), .In(wd[1]), .ConflictCnt(cnt[1])
   );

   regfile_wb_arbiter #(.CNT_W(4)) u2 (
      .Clk(clk), .Rst(rst),
      .ValidA(va), .AddrA(aa), .DataA(da), .ReadyA(ready_a[2]),
      .ValidB(vb), .AddrB(ab), .DataB(db), .ReadyB(ready_b[2]),
      .WriteEn(we[2]), .WriteAddr(wa[2]), .In(wd[2]), .ConflictCnt(cnt2_raw)
   );

   assign cnt[2] = {12'b0, cnt2_raw};

   // ---------------- scoreboard helper ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          zro  [3] = '{1, 0, 1};
   int          cmax [3] = '{65535, 65535, 15};
   bit          m_ok = 1'b0;
   logic        m_last [3];
   logic        m_we   [3];
   logic [4:0]  m_wa   [3];
   logic [31:0] m_wd   [3];
   int          m_cnt  [3];

   function automatic logic m_ra(input int i);
      return !rst && va && (!vb || m_last[i]);
   endfunction

   function automatic logic m_rb(input int i);
      return !rst && vb && (!va || !m_last[i]);
   endfunction

   always @(posedge clk) begin
      m_ok <= m_ok | rst;
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_last[i] <= 1'b1;
            m_we[i]   <= 1'b0;
            m_wa[i]   <= '0;
            m_wd[i]   <= '0;
            m_cnt[i]  <= 0;
         end else begin
            if (m_ra(i)) begin
               m_last[i] <= 1'b0;
               m_wa[i]   <= aa;
               m_wd[i]   <= da;
               m_we[i]   <= !(zro[i] != 0 && aa == 5'd0);
            end else if (m_rb(i)) begin
               m_last[i] <= 1'b1;
               m_wa[i]   <= ab;
               m_wd[i]   <= db;
               m_we[i]   <= !(zro[i] != 0 && ab == 5'd0);
            end else begin
               m_we[i]   <= 1'b0;
            end
            if (va && vb && m_cnt[i] < cmax[i]) m_cnt[i] <= m_cnt[i] + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.ReadyA", i), ready_a[i], m_ra(i));
            chk($sformatf("u%0d.ReadyB", i), ready_b[i], m_rb(i));
            chk($sformatf("u%0d.never_both", i), ready_a[i] & ready_b[i], 0);
            chk($sformatf("u%0d.WriteEn", i), we[i], m_we[i]);
            chk($sformatf("u%0d.WriteAddr", i), wa[i], m_wa[i]);
            chk($sformatf("u%0d.In", i), wd[i], m_wd[i]);
            chk($sformatf("u%0d.ConflictCnt", i), cnt[i], m_cnt[i]);
         end
      end
   end

   // Register file fed from the DUT write port, for the read-after-write check.
   logic [31:0] rf [32];
   always @(posedge clk) if (we[0]) rf[wa[0]] <= wd[0];

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iva, input logic [4:0] iaa, input logic [31:0] ida,
                        input logic ivb, input logic [4:0] iab, input logic [31:0] idb);
      va = iva; aa = iaa; da = ida;
      vb = ivb; ab = iab; db = idb;
   endtask

   initial begin
      // Reset with both sources requesting
      rst = 1'b1;
      drive(1, 5'd3, 32'h1111, 1, 5'd4, 32'h2222);
      repeat (3) begin
         @(negedge clk);
         chk("rst.ReadyA", ready_a[0], 0);
         chk("rst.ReadyB", ready_b[0], 0);
         chk("rst.WriteEn", we[0], 0);
         chk("rst.ConflictCnt", cnt[0], 0);
      end

      // Lone write from A
      tick();
      rst = 1'b0;
      drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
      @(negedge clk);
      chk("single.ReadyA", ready_a[0], 1);
      chk("single.ReadyB", ready_b[0], 0);
      tick();
      drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(negedge clk);
      chk("single.WriteEn", we[0], 1);
      chk("single.WriteAddr", wa[0], 5);
      chk("single.In", wd[0], 32'hDEADBEEF);
      tick();
      @(negedge clk);
      chk("single.WriteEn_drop", we[0], 0);

      // Continuous contention after a fresh reset: A,B,A,B,A,B
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1, 5'd10, 32'hA0, 1, 5'd20, 32'hB0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("rr.ReadyA[%0d]", k), ready_a[0], (k % 2 == 0));
         chk($sformatf("rr.ReadyB[%0d]", k), ready_b[0], (k % 2 == 1));
         if (k > 0) chk($sformatf("rr.WriteAddr[%0d]", k), wa[0], (k % 2 == 1) ? 10 : 20);
         tick();
      end
      drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(negedge clk);
      chk("rr.WriteAddr_last", wa[0], 20);
      chk("rr.ConflictCnt", cnt[0], 6);

      // Same address from both sources; B won last, so A goes first
      tick();
      drive(1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
      @(negedge clk);
      chk("same.ReadyA", ready_a[0], 1);
      tick();
      va = 1'b0;
      @(negedge clk);
      chk("same.ReadyB", ready_b[0], 1);
      chk("same.first_In", wd[0], 32'h1);
      tick();
      vb = 1'b0;
      @(negedge clk);
      chk("same.second_In", wd[0], 32'h2);
      chk("same.second_WriteAddr", wa[0], 7);
      tick();
      @(negedge clk);
      chk("same.reg7", rf[7], 32'h2);

      // Write to register 0 with and without ZERO_RO
      tick();
      drive(0, 5'd0, 32'h0, 1, 5'd0, 32'h55);
      @(negedge clk);
      chk("zero.ReadyB_ro", ready_b[0], 1);
      chk("zero.ReadyB_rw", ready_b[1], 1);
      tick();
      vb = 1'b0;
      @(negedge clk);
      chk("zero.WriteEn_ro", we[0], 0);
      chk("zero.WriteEn_rw", we[1], 1);
      chk("zero.WriteAddr_rw", wa[1], 0);
      chk("zero.In_rw", wd[1], 32'h55);

      // 20 contention cycles: 4-bit counter saturates, 16-bit one keeps counting
      tick();
      drive(1, 5'd1, 32'hC1, 1, 5'd2, 32'hC2);
      repeat (20) tick();
      drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(negedge clk);
      chk("sat.cnt4", cnt[2], 15);
      chk("sat.cnt16", cnt[0], 27);

      // Reset the cycle after a grant
      tick();
      drive(1, 5'd9, 32'h99, 0, 5'd0, 32'h0);
      @(negedge clk);
      chk("rstmid.ReadyA", ready_a[0], 1);
      tick();
      rst = 1'b1;
      drive(1, 5'd9, 32'h99, 1, 5'd8, 32'h88);
      @(negedge clk);
      chk("rstmid.ReadyA_in_rst", ready_a[0], 0);
      chk("rstmid.ReadyB_in_rst", ready_b[0], 0);
      chk("rstmid.WriteEn_in_rst", we[0], 1);
      tick();
      rst = 1'b0;
      drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(negedge clk);
      chk("rstmid.WriteEn_after", we[0], 0);
      chk("rstmid.cnt16_after", cnt[0], 0);
      chk("rstmid.cnt4_after", cnt[2], 0);

      // First tie after reset goes to A
      tick();
      drive(1, 5'd12, 32'h12, 1, 5'd13, 32'h13);
      @(negedge clk);
      chk("postrst.ReadyA", ready_a[0], 1);
      tick();
      drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      @(negedge clk);
      chk("postrst.WriteAddr", wa[0], 12);
      tick();
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
